// File: rtl/cpu_types_pkg.sv
// Types shared by the caches, the RAM model and the memory arbiter.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache/RAM bus seen by the arbiter: master = arbiter side, slave = caches + RAM side.
import cpu_types_pkg::*;

interface mem_arbiter_if;
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN, dWEN;
  word_t     daddr, dstore;
  logic      dlock;
  logic      dwait;
  word_t     dload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  word_t     icnt, dcnt;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, dlock, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, icnt, dcnt
  );
  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, dlock, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, icnt, dcnt
  );
endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating icache wait counter; starve flags that the limit has been reached.
module arb_starve_ctr #(
  parameter int STARVE_LIMIT = 8,
  parameter int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic          o_starve,
  output logic [CW-1:0] o_count
);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                     r_cnt <= '0;
    else if (i_clr)                r_cnt <= '0;
    else if (i_inc && r_cnt != LIM) r_cnt <= r_cnt + CW'(1);
  end

  assign o_count  = r_cnt;
  assign o_starve = (r_cnt == LIM);
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: dcache priority, dlock bursts, icache starvation bound.
// Optional transaction counters built only when ARB_STATS_EN is defined.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.master bus
);
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, DSERV, ISERV} arb_state_t;

  arb_state_t    r_state, w_next;
  logic          w_dreq, w_ireq, w_acc, w_starve;
  logic          w_icomp, w_dcomp;
  logic          w_ren, w_wen, w_iwait, w_dwait;
  word_t         w_addr, w_store;
  logic [CW-1:0] w_scnt;

  assign w_dreq = bus.dREN | bus.dWEN;
  assign w_ireq = bus.iREN;
  assign w_acc  = (bus.ramstate == ACCESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // A dropped request releases the grant without a completion, even on ACCESS.
  always_comb begin
    w_next  = r_state;
    w_ren   = 1'b0;
    w_wen   = 1'b0;
    w_addr  = '0;
    w_store = '0;
    w_iwait = 1'b1;
    w_dwait = 1'b1;
    w_icomp = 1'b0;
    w_dcomp = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_dreq && !(w_starve && w_ireq)) w_next = DSERV;
        else if (w_ireq)                     w_next = ISERV;
      end
      DSERV: begin
        w_addr  = bus.daddr;
        w_store = bus.dstore;
        if (!w_dreq) w_next = IDLE;
        else begin
          w_wen = bus.dWEN;
          w_ren = bus.dREN & ~bus.dWEN;
          if (w_acc) begin
            w_dwait = 1'b0;
            w_dcomp = 1'b1;
            w_next  = bus.dlock ? DSERV : IDLE;
          end
        end
      end
      ISERV: begin
        w_addr = bus.iaddr;
        if (!w_ireq) w_next = IDLE;
        else begin
          w_ren = 1'b1;
          if (w_acc) begin
            w_iwait = 1'b0;
            w_icomp = 1'b1;
            w_next  = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT), .CW(CW)) u_starve (
    .CLK      (CLK),
    .nRST     (nRST),
    .i_inc    (w_ireq & w_iwait),
    .i_clr    (w_icomp),
    .o_starve (w_starve),
    .o_count  (w_scnt)
  );

  always_ff @(posedge CLK) begin
    if (nRST) assert (w_scnt <= LIM);
  end

  assign bus.ramREN   = w_ren;
  assign bus.ramWEN   = w_wen;
  assign bus.ramaddr  = w_addr;
  assign bus.ramstore = w_store;
  assign bus.iwait    = w_iwait;
  assign bus.dwait    = w_dwait;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;

`ifdef ARB_STATS_EN
  word_t r_icnt, r_dcnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_icnt <= '0;
      r_dcnt <= '0;
    end else begin
      if (w_icomp) r_icnt <= r_icnt + 32'd1;
      if (w_dcomp) r_dcnt <= r_dcnt + 32'd1;
    end
  end

  assign bus.icnt = r_icnt;
  assign bus.dcnt = r_dcnt;
`else
  assign bus.icnt = '0;
  assign bus.dcnt = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a grant-owner model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int LIMIT = 8;
`ifdef ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  mem_arbiter_if bus();
  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  // Model: who owns the RAM port (0 none, 1 dcache, 2 icache), wait count, completions.
  int    m_own, m_scnt, n_own, n_scnt;
  word_t m_icnt, m_dcnt, n_icnt, n_dcnt;

  task automatic chk(input string tag, input word_t got, input word_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_scnt = 0; m_icnt = 0; m_dcnt = 0;
  endtask

  task automatic check_outputs();
    bit    dreq, ireq, acc, ren, wen, iw, dw, idone, ddone;
    word_t addr, store;
    dreq = bus.dREN | bus.dWEN;
    ireq = bus.iREN;
    acc  = (bus.ramstate == ACCESS);
    ren = 0; wen = 0; iw = 1; dw = 1; addr = 0; store = 0; idone = 0; ddone = 0;
    if (m_own == 1) begin
      addr = bus.daddr; store = bus.dstore;
      if (dreq) begin
        wen = bus.dWEN; ren = bus.dREN && !bus.dWEN;
        ddone = acc; dw = !acc;
      end
    end else if (m_own == 2) begin
      addr = bus.iaddr;
      if (ireq) begin
        ren = 1; idone = acc; iw = !acc;
      end
    end
    chk("ramREN",   32'(bus.ramREN), 32'(ren));
    chk("ramWEN",   32'(bus.ramWEN), 32'(wen));
    chk("ramaddr",  bus.ramaddr, addr);
    chk("ramstore", bus.ramstore, store);
    chk("iwait",    32'(bus.iwait), 32'(iw));
    chk("dwait",    32'(bus.dwait), 32'(dw));
    chk("iload",    bus.iload, bus.ramload);
    chk("dload",    bus.dload, bus.ramload);
    chk("icnt",     bus.icnt, STATS ? m_icnt : 32'd0);
    chk("dcnt",     bus.dcnt, STATS ? m_dcnt : 32'd0);
    chk("scnt",     32'(dut.w_scnt), 32'(m_scnt));
    // next model state
    n_icnt = m_icnt + (idone ? 1 : 0);
    n_dcnt = m_dcnt + (ddone ? 1 : 0);
    if (idone)                          n_scnt = 0;
    else if (ireq && iw && m_scnt < LIMIT) n_scnt = m_scnt + 1;
    else                                n_scnt = m_scnt;
    case (m_own)
      0:       n_own = (dreq && !(m_scnt == LIMIT && ireq)) ? 1 : (ireq ? 2 : 0);
      1:       n_own = (!dreq) ? 0 : ((acc && !bus.dlock) ? 0 : 1);
      default: n_own = (!ireq || acc) ? 0 : 2;
    endcase
  endtask

  task automatic tick();
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic adv();
    @(posedge CLK);
    if (!nRST) model_reset();
    else begin
      m_own = n_own; m_scnt = n_scnt; m_icnt = n_icnt; m_dcnt = n_dcnt;
    end
    #1;
  endtask

  task automatic cyc();
    tick();
    adv();
  endtask

  task automatic idle_inputs();
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0; bus.daddr = 0;
    bus.dstore = 0; bus.dlock = 0; bus.ramload = 0; bus.ramstate = FREE;
  endtask

  initial begin
    int hit;
    model_reset();
    idle_inputs();
    // reset state
    tick();
    chk("rst_ramREN", 32'(bus.ramREN), 0);
    chk("rst_iwait",  32'(bus.iwait), 1);
    adv();
    nRST = 1;

    // single icache read with immediate ACCESS
    bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
    cyc();
    tick();
    chk("t1_iwait", 32'(bus.iwait), 0);
    chk("t1_iload", bus.iload, 32'hDEADBEEF);
    adv();
    bus.iREN = 0;
    cyc();

    // dcache write drives the write strobe, address and data
    bus.dWEN = 1; bus.dREN = 1; bus.daddr = 32'h3100; bus.dstore = 32'h5; bus.ramstate = BUSY;
    cyc();
    tick();
    chk("wr_ramWEN",   32'(bus.ramWEN), 1);
    chk("wr_ramREN",   32'(bus.ramREN), 0);
    chk("wr_ramaddr",  bus.ramaddr, 32'h3100);
    chk("wr_ramstore", bus.ramstore, 32'h5);
    adv();
    bus.ramstate = ACCESS;
    cyc();
    bus.dWEN = 0; bus.dREN = 0;
    cyc();

    // locked two-word burst with icache waiting
    bus.iREN = 1; bus.iaddr = 32'h200; bus.dREN = 1; bus.dlock = 1; bus.daddr = 32'h80;
    cyc();
    tick();
    chk("burst_w0_dwait", 32'(bus.dwait), 0);
    adv();
    bus.daddr = 32'h84; bus.dlock = 0;
    tick();
    chk("burst_w1_addr",  bus.ramaddr, 32'h84);
    chk("burst_w1_dwait", 32'(bus.dwait), 0);
    adv();
    bus.dREN = 0;
    cyc();
    tick();
    chk("burst_then_i", 32'(bus.iwait), 0);
    adv();
    bus.iREN = 0;
    cyc();

    // starvation: dcache keeps requesting, icache must win after LIMIT wait cycles
    bus.iREN = 1; bus.dREN = 1; bus.ramstate = ACCESS;
    hit = -1;
    for (int k = 0; k < 40 && hit < 0; k++) begin
      tick();
      if (bus.iwait == 1'b0) hit = k;
      adv();
    end
    chk("starve_cycle", 32'(hit), 32'(LIMIT + 1));
    bus.iREN = 0; bus.dREN = 0;
    cyc();

    // async reset in the middle of a BUSY write
    bus.dWEN = 1; bus.daddr = 32'h700; bus.ramstate = BUSY;
    cyc();
    tick();
    #2 nRST = 0;
    #1;
    chk("mrst_ramWEN", 32'(bus.ramWEN), 0);
    chk("mrst_dwait",  32'(bus.dwait), 1);
    chk("mrst_icnt",   bus.icnt, 0);
    chk("mrst_dcnt",   bus.dcnt, 0);
    model_reset();
    @(posedge CLK);
    #1;
    nRST = 1;
    bus.dWEN = 0;
    cyc();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      bus.iREN    = ($urandom_range(0, 3) != 0);
      bus.iaddr   = $urandom;
      bus.dREN    = ($urandom_range(0, 2) == 0);
      bus.dWEN    = ($urandom_range(0, 4) == 0);
      bus.daddr   = $urandom;
      bus.dstore  = $urandom;
      bus.dlock   = ($urandom_range(0, 2) == 0);
      bus.ramload = $urandom;
      bus.ramstate = ($urandom_range(0, 1) == 0) ? ACCESS : ramstate_t'($urandom_range(0, 3));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
